// File: rtl/friet_permutation_host_driver.sv
// ---------------------------------------------------------------------------
// friet_permutation_host_driver
//
// Host-side initiator for the streaming Friet permutation core. A 384-bit
// state is captured in parallel, streamed to the core least-significant
// word first, the core is started, and the permuted state is drained back
// (again least-significant word first) and presented in parallel.
//
// Parameters:
//   BUFFER_LENGTH  stream word width; must divide 384 (1..128, powers of 2)
//
// Ports:
//   clk                  rising-edge clock
//   arst                 asynchronous reset, active-high
//   host_start           request a permutation (sampled in IDLE only)
//   host_state_in        state to permute, captured on accepted host_start
//   host_state_out       permuted state, updated together with host_done
//   host_done            one-cycle pulse when host_state_out is updated
//   host_busy            high in every state except IDLE
//   core_start           one-cycle start pulse to the core
//   core_data_in_valid   word on core_data_in is written this cycle
//   core_data_in         word to the core
//   core_data_in_ready   core accepts input words
//   core_data_out_ready  driver accepts output words (high in UNLOAD)
//   core_data_out        word from the core
//   core_data_out_valid  core_data_out holds a word
//   core_finish          core permutation complete pulse
//   core_free            core idle
// ---------------------------------------------------------------------------
module friet_permutation_host_driver #(
    parameter int unsigned BUFFER_LENGTH = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     host_start,
    input  logic [383:0]             host_state_in,
    output logic [383:0]             host_state_out,
    output logic                     host_done,
    output logic                     host_busy,
    output logic                     core_start,
    output logic                     core_data_in_valid,
    output logic [BUFFER_LENGTH-1:0] core_data_in,
    input  logic                     core_data_in_ready,
    output logic                     core_data_out_ready,
    input  logic [BUFFER_LENGTH-1:0] core_data_out,
    input  logic                     core_data_out_valid,
    input  logic                     core_finish,
    input  logic                     core_free
);

    localparam int unsigned STATE_W = 384;
    localparam int unsigned WORDS   = STATE_W / BUFFER_LENGTH;
    localparam int unsigned CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FREE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [STATE_W-1:0] tx_sr;
    logic [STATE_W-1:0] rx_sr;
    logic [STATE_W-1:0] rx_next;
    logic               load_beat;
    logic               unload_beat;

    // A load beat needs the core both ready and free; stalled cycles leave
    // tx_sr untouched so core_data_in holds its word.
    always_comb begin
        load_beat          = (state == S_LOAD) && core_data_in_ready && core_free;
        unload_beat        = core_data_out_valid && core_data_out_ready;
        rx_next            = {core_data_out, rx_sr[STATE_W-1:BUFFER_LENGTH]};
        core_data_in_valid = load_beat;
        core_data_in       = tx_sr[BUFFER_LENGTH-1:0];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            tx_sr               <= '0;
            rx_sr               <= '0;
            host_state_out      <= '0;
            host_done           <= 1'b0;
            host_busy           <= 1'b0;
            core_start          <= 1'b0;
            core_data_out_ready <= 1'b0;
        end else begin
            core_start <= 1'b0;
            host_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host_start) begin
                        tx_sr     <= host_state_in;
                        cnt       <= '0;
                        host_busy <= 1'b1;
                        state     <= core_free ? S_LOAD : S_WAIT_FREE;
                    end
                end
                S_WAIT_FREE: begin
                    if (core_free) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_beat) begin
                        tx_sr <= tx_sr >> BUFFER_LENGTH;
                        if (cnt == LAST_WORD) begin
                            cnt        <= '0;
                            core_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (core_finish) begin
                        core_data_out_ready <= 1'b1;
                        state               <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (unload_beat) begin
                        rx_sr <= rx_next;
                        if (cnt == LAST_WORD) begin
                            // Result and done are registered on the edge into
                            // DONE so both are visible during the DONE cycle.
                            cnt                 <= '0;
                            core_data_out_ready <= 1'b0;
                            host_state_out      <= rx_next;
                            host_done           <= 1'b1;
                            state               <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    host_busy <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friet_permutation_host_driver.sv
module tb_friet_permutation_host_driver;

    localparam int unsigned BL      = 8;
    localparam int unsigned WORDS   = 384 / BL;
    localparam int          TIMEOUT = 3000;

    logic            clk = 1'b0;
    logic            arst;
    logic            host_start;
    logic [383:0]    host_state_in;
    logic [383:0]    host_state_out;
    logic            host_done;
    logic            host_busy;
    logic            core_start;
    logic            core_data_in_valid;
    logic [BL-1:0]   core_data_in;
    logic            core_data_in_ready = 1'b1;
    logic            core_data_out_ready;
    logic [BL-1:0]   core_data_out = '0;
    logic            core_data_out_valid = 1'b0;
    logic            core_finish = 1'b0;
    logic            core_free = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    friet_permutation_host_driver #(.BUFFER_LENGTH(BL)) dut (
        .clk                 (clk),
        .arst                (arst),
        .host_start          (host_start),
        .host_state_in       (host_state_in),
        .host_state_out      (host_state_out),
        .host_done           (host_done),
        .host_busy           (host_busy),
        .core_start          (core_start),
        .core_data_in_valid  (core_data_in_valid),
        .core_data_in        (core_data_in),
        .core_data_in_ready  (core_data_in_ready),
        .core_data_out_ready (core_data_out_ready),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid),
        .core_finish         (core_finish),
        .core_free           (core_free)
    );

    // Stand-in permutation: a rotate plus a wide add, so word order matters.
    function automatic logic [383:0] ref_perm(input logic [383:0] x);
        logic [383:0] k;
        k = {12{32'h9E3779B9}};
        return ((x << 13) | (x >> 371)) + k;
    endfunction

    // ---------------- behavioural core ----------------
    logic         core_rst = 1'b1;
    logic         hold_busy = 1'b0;
    int           c_phase = 0;
    int           c_in_cnt = 0;
    int           c_timer = 0;
    int           c_idx = 0;
    logic [383:0] c_buf = '0;
    logic [383:0] c_res = '0;

    always @(posedge clk) begin
        if (core_rst) begin
            c_phase = 0; c_in_cnt = 0; c_idx = 0;
            core_finish <= 1'b0; core_data_out_valid <= 1'b0;
            core_data_out <= '0; core_free <= 1'b1;
        end else begin
            case (c_phase)
                0: begin
                    if (core_data_in_valid && c_in_cnt < int'(WORDS)) begin
                        c_buf[c_in_cnt*BL +: BL] = core_data_in;
                        c_in_cnt++;
                    end
                    if (core_start) begin
                        c_res = ref_perm(c_buf);
                        c_timer = int'($urandom_range(2, 8));
                        c_phase = 1;
                        core_free <= 1'b0;
                    end else begin
                        core_free <= !hold_busy;
                    end
                end
                1: begin
                    if (c_timer == 0) begin
                        core_finish <= 1'b1; c_phase = 2; c_idx = 0;
                    end else begin
                        c_timer--;
                    end
                end
                default: begin
                    core_finish <= 1'b0;
                    if (core_data_out_valid && core_data_out_ready) c_idx++;
                    if (c_idx == int'(WORDS)) begin
                        core_data_out_valid <= 1'b0;
                        c_phase = 0; c_in_cnt = 0;
                        core_free <= !hold_busy;
                    end else begin
                        core_data_out_valid <= 1'b1;
                        core_data_out <= c_res[c_idx*BL +: BL];
                    end
                end
            endcase
        end
    end

    // ---------------- monitor and input-ready driver ----------------
    int            cyc = 0, in_beats = 0, out_beats = 0, starts = 0, dones = 0;
    int            first_in_cyc = 0, last_in_cyc = 0, start_cyc = 0;
    int            in_base = 0, stall_at = -1, stall_left = 0;
    bit            rand_ready = 1'b0;
    logic [BL-1:0] sent[$];

    always @(negedge clk) begin
        cyc++;
        if (core_data_in_valid) begin
            if (in_beats == in_base) first_in_cyc = cyc;
            in_beats++;
            last_in_cyc = cyc;
            sent.push_back(core_data_in);
        end
        if (core_data_out_valid && core_data_out_ready) out_beats++;
        if (core_start) begin starts++; start_cyc = cyc; end
        if (host_done) dones++;
        if (stall_left > 0) begin
            core_data_in_ready = 1'b0; stall_left--;
        end else if (stall_at >= 0 && in_beats - in_base == stall_at) begin
            core_data_in_ready = 1'b0; stall_left = 2; stall_at = -1;
        end else begin
            core_data_in_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [383:0] st);
        host_state_in = st;
        host_start = 1'b1;
        step();
        host_start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (host_done === 1'b1) begin got = 1'b1; break; end
            step();
        end
    endtask

    function automatic logic [383:0] rand_state();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_out"},   host_state_out, '0);
        check({tag, "_done"},  384'(host_done), '0);
        check({tag, "_busy"},  384'(host_busy), '0);
        check({tag, "_start"}, 384'(core_start), '0);
        check({tag, "_valid"}, 384'(core_data_in_valid), '0);
        check({tag, "_din"},   384'(core_data_in), '0);
        check({tag, "_ready"}, 384'(core_data_out_ready), '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [383:0] st;
        logic [383:0] v;
        bit           got;
        int           lc, b_in, b_out, b_st, b_dn;

        arst = 1'b1; core_rst = 1'b1; host_start = 1'b0; host_state_in = '0;
        repeat (3) step();
        reset_outputs_zero("rst");
        arst = 1'b0; core_rst = 1'b0;
        repeat (10) step();
        reset_outputs_zero("idle");
        check_int("idle_core_starts", starts, 0);

        // Byte-ramp state: words must leave LSB first, back to back.
        for (int k = 0; k < 48; k++) st[k*8 +: 8] = 8'(48 - k);
        sent.delete(); in_base = in_beats; b_st = starts; b_dn = dones; lc = cyc;
        launch(st);
        wait_done(got);
        check_int("ramp_done_seen", int'(got), 1);
        check("ramp_result", host_state_out, ref_perm(st));
        check("ramp_busy_in_done", 384'(host_busy), 384'(1));
        check_int("ramp_in_beats", in_beats - in_base, int'(WORDS));
        check_int("ramp_first_beat_cyc", first_in_cyc, lc + 1);
        check_int("ramp_last_beat_cyc", last_in_cyc, first_in_cyc + int'(WORDS) - 1);
        check_int("ramp_start_cyc", start_cyc, last_in_cyc + 1);
        check_int("ramp_starts", starts - b_st, 1);
        check_int("ramp_dones", dones - b_dn, 1);
        for (int k = 0; k < 48; k++) check($sformatf("ramp_word%0d", k), 384'(sent[k]), 384'(48 - k));
        step();
        check("ramp_idle_busy", 384'(host_busy), '0);
        check("ramp_done_pulse", 384'(host_done), '0);
        check("ramp_out_hold", host_state_out, ref_perm(st));

        // All-zero then random states with random input-ready gaps.
        rand_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            v = (t == 0) ? '0 : rand_state();
            in_base = in_beats; b_out = out_beats;
            launch(v);
            wait_done(got);
            check_int($sformatf("rnd%0d_done_seen", t), int'(got), 1);
            check($sformatf("rnd%0d_result", t), host_state_out, ref_perm(v));
            check_int($sformatf("rnd%0d_in_beats", t), in_beats - in_base, int'(WORDS));
            check_int($sformatf("rnd%0d_out_beats", t), out_beats - b_out, int'(WORDS));
            step();
        end
        rand_ready = 1'b0;

        // Three-cycle ready drop at word 10.
        v = rand_state();
        sent.delete(); in_base = in_beats; stall_at = 10;
        launch(v);
        wait_done(got);
        check_int("stall_done_seen", int'(got), 1);
        check("stall_result", host_state_out, ref_perm(v));
        check_int("stall_in_beats", in_beats - in_base, int'(WORDS));
        for (int k = 0; k < 48; k++) check($sformatf("stall_word%0d", k), 384'(sent[k]), 384'(v[k*8 +: 8]));
        step();

        // Core busy at request time: driver must wait before loading.
        hold_busy = 1'b1;
        step();
        v = rand_state();
        in_base = in_beats;
        launch(v);
        repeat (5) step();
        check("wfree_busy", 384'(host_busy), 384'(1));
        check_int("wfree_no_beats", in_beats - in_base, 0);
        hold_busy = 1'b0;
        wait_done(got);
        check_int("wfree_done_seen", int'(got), 1);
        check("wfree_result", host_state_out, ref_perm(v));
        step();

        // host_start during RUN and during DONE is ignored.
        v = rand_state();
        b_st = starts; b_dn = dones;
        launch(v);
        for (int i = 0; i < TIMEOUT && starts == b_st; i++) step();
        check_int("poke_start_seen", starts - b_st, 1);
        step();
        host_start = 1'b1; step(); host_start = 1'b0;
        wait_done(got);
        check_int("poke_done_seen", int'(got), 1);
        host_start = 1'b1; step(); host_start = 1'b0;
        repeat (5) step();
        check_int("poke_starts", starts - b_st, 1);
        check_int("poke_dones", dones - b_dn, 1);
        check("poke_idle", 384'(host_busy), '0);
        check("poke_result", host_state_out, ref_perm(v));

        // Reset in the middle of UNLOAD, then a clean transfer.
        v = rand_state();
        b_out = out_beats;
        launch(v);
        for (int i = 0; i < TIMEOUT && out_beats - b_out < 20; i++) step();
        check_int("arst_reached_word20", out_beats - b_out, 20);
        arst = 1'b1; core_rst = 1'b1;
        #1;
        reset_outputs_zero("arst");
        step(); step();
        reset_outputs_zero("arst_hold");
        arst = 1'b0; core_rst = 1'b0;
        step();
        v = rand_state();
        in_base = in_beats; b_out = out_beats; b_dn = dones;
        launch(v);
        wait_done(got);
        check_int("post_done_seen", int'(got), 1);
        check("post_result", host_state_out, ref_perm(v));
        check_int("post_in_beats", in_beats - in_base, int'(WORDS));
        check_int("post_out_beats", out_beats - b_out, int'(WORDS));
        check_int("post_dones", dones - b_dn, 1);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
